pvr_vram_arb: RTL and testbench
===============================

PVR_VRAM_ARB -- requirements
Module: pvr_vram_arb

Interface
REQ-001 The module SHALL have parameter READ_LAT, default 1: cycles from read-command acceptance until vram_din holds the data (range 1-4).
REQ-002 The module SHALL have parameter NREQ, fixed at 3: requesters 0=region-array parser, 1=polygon/ISP fetch, 2=texture fetch.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- req_rd  in  3  per-requester read request (level, held until ack)
- req_wr  in  3  per-requester write request (level, held until ack)
- req_addr  in  72  byte address, requester n on bits [24n+23:24n]
- req_wdata  in  96  write data, requester n on bits [32n+31:32n]
- req_ack  out  3  one-cycle pulse: command accepted by VRAM
- req_rvalid  out  3  one-cycle pulse: req_rdata belongs to requester n
- req_rdata  out  32  shared read-return data
- vram_rd, vram_wr  out  1 each  command strobes to the VRAM port
- vram_addr  out  24  command address
- vram_dout  out  32  write data
- vram_din  in  32  read data, valid READ_LAT cycles after acceptance
- vram_wait  in  1  VRAM stall; a command is accepted only in a cycle with a strobe high and vram_wait low

Function
REQ-010 The FSM SHALL have states IDLE, CMD, ACK.
REQ-011 In IDLE, the pending set SHALL be (req_rd|req_wr); if it is non-empty, the block SHALL choose a winner w and register its addr, wdata and type, then enter CMD on the next edge.
REQ-012 In CMD, exactly one of vram_rd/vram_wr SHALL be high, with vram_addr/vram_dout stable; these SHALL hold unchanged while vram_wait=1.
REQ-013 In the CMD cycle with vram_wait=0, the command SHALL be accepted; next edge -> ACK, strobes low, req_ack[w]=1 for exactly that cycle.
REQ-014 In ACK, requester w SHALL be excluded from arbitration; any other pending requester SHALL be selected as in IDLE, otherwise return to IDLE; peak rate is one command per 2 cycles.
REQ-015 If req_rd and req_wr are both high for one requester, the request SHALL be treated as a write; the read SHALL be ignored.
REQ-016 Each accepted read SHALL push w into a READ_LAT-deep ID pipeline; at the end of the pipeline, req_rdata <= vram_din and req_rvalid[id] <= 1, so response appears READ_LAT+1 cycles after the acceptance cycle.
REQ-017 Accepted writes SHALL produce no rvalid.
REQ-018 Read returns SHALL be delivered in acceptance order and never dropped; up to READ_LAT reads may be outstanding, and at most one rvalid bit SHALL be high per cycle.
REQ-019 Requester inputs sampled during CMD SHALL NOT alter the command in flight; a request deasserted before ack is a protocol violation (undefined).
REQ-020 req_rdata SHALL hold its last value when no rvalid is high.

Reset
REQ-030 While reset_n=0, the block SHALL be in state IDLE with all outputs 0 (vram_addr, vram_dout and req_rdata included), an empty ID pipeline, and the round-robin pointer at 2, so requester 0 ranks first.
REQ-031 Reset asserted mid-command or with reads outstanding SHALL discard them; no rvalid or ack SHALL appear after reset deassertion for pre-reset commands.

Configuration
REQ-040 The macro VRAM_ARB_RR_EN SHALL select the arbitration policy.
- Defined: round-robin; priority starts at (last winner+1) mod 3, and the pointer updates on acceptance only.
- Undefined: fixed priority 0 > 1 > 2; the pointer logic is absent.

Verification
REQ-050 With READ_LAT=1, req_rd[0]=1, addr0=0x000100, wait=0: vram_rd high 1 cycle later with addr 0x000100; ack[0] the next cycle; vram_din=0xDEADBEEF during the cycle after acceptance -> rvalid[0], rdata=0xDEADBEEF one cycle later.
REQ-051 With all three requesters reading continuously and RR_EN defined: grant order 0,1,2,0,1,2; with RR_EN undefined: order 0,1,0,1 and requester 2 starved.
REQ-052 With req_wr[1]=1, addr 0x7FFFFC, wdata 0x12345678, and vram_wait=1 for 3 CMD cycles: vram_wr, addr and dout stay stable for 4 cycles; ack[1] after the wait drops; no rvalid.
REQ-053 With READ_LAT=3 and reads from 2 then 0 accepted back-to-back (via ACK): rvalid[2] then rvalid[0], each with the matching vram_din, in order.
REQ-054 With req_rd[0] and req_wr[0] both high: a write is issued.
REQ-055 With reset_n pulsed low during CMD with one read outstanding: outputs go to 0 immediately, and no ack or rvalid follows.

Source files
------------

// File: rtl/pvr_vram_arb.sv
// VRAM command arbiter for three requesters with in-order read return.
// Define VRAM_ARB_RR_EN for round-robin arbitration; default is fixed 0>1>2.
module pvr_vram_arb #(
  parameter int READ_LAT = 1,
  parameter int NREQ     = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [24*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_rvalid,
  output logic [31:0]          req_rdata,
  output logic                 vram_rd,
  output logic                 vram_wr,
  output logic [23:0]          vram_addr,
  output logic [31:0]          vram_dout,
  input  logic [31:0]          vram_din,
  input  logic                 vram_wait
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ACK
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          win_q, win_d;
  logic [23:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                load;

  logic [23:0]         addr_a  [NREQ];
  logic [31:0]         wdata_a [NREQ];

  logic [NREQ-1:0]     excl;
  logic [NREQ-1:0]     pend;
  logic [1:0]          base;
  logic [2:0]          cand;
  logic [1:0]          sel;
  logic                found;

  logic                accept;
  logic                accept_rd;

  logic [READ_LAT-1:0] pv_q;
  logic [1:0]          pid_q [READ_LAT];
  logic [NREQ-1:0]     rvalid_q;
  logic [31:0]         rdata_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign addr_a[g]  = req_addr[24*g +: 24];
    assign wdata_a[g] = req_wdata[32*g +: 32];
  end

`ifdef VRAM_ARB_RR_EN
  logic [1:0] ptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 2'd2;
    end else if (accept) begin
      ptr_q <= win_q;
    end
  end

  assign base = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
`else
  assign base = 2'd0;
`endif

  // The requester just acked still holds its request this cycle.
  always_comb begin
    excl  = (state_q == ACK) ? (NREQ'(1) << win_q) : '0;
    pend  = (req_rd | req_wr) & ~excl;
    found = 1'b0;
    sel   = 2'd0;
    cand  = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, base} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      if (!found && pend[cand[1:0]]) begin
        found = 1'b1;
        sel   = cand[1:0];
      end
    end
  end

  assign accept    = (state_q == CMD) && !vram_wait;
  assign accept_rd = accept && !wr_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, ACK: begin
        if (found) begin
          load    = 1'b1;
          state_d = CMD;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (!vram_wait) begin
          state_d = ACK;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      win_d   = sel;
      addr_d  = addr_a[sel];
      wdata_d = wdata_a[sel];
      wr_d    = req_wr[sel];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      addr_q  <= 24'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Requester IDs travel alongside the VRAM read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pv_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pid_q[i] <= 2'd0;
      end
      rvalid_q <= '0;
      rdata_q  <= 32'd0;
    end else begin
      pv_q[0]  <= accept_rd;
      pid_q[0] <= win_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
      rvalid_q <= '0;
      if (pv_q[READ_LAT-1]) begin
        rvalid_q <= NREQ'(1) << pid_q[READ_LAT-1];
        rdata_q  <= vram_din;
      end
    end
  end

  assign vram_rd    = (state_q == CMD) && !wr_q;
  assign vram_wr    = (state_q == CMD) && wr_q;
  assign vram_addr  = addr_q;
  assign vram_dout  = wdata_q;
  assign req_ack    = (state_q == ACK) ? (NREQ'(1) << win_q) : '0;
  assign req_rvalid = rvalid_q;
  assign req_rdata  = rdata_q;

endmodule

// File: tb/tb_pvr_vram_arb.sv
// Scoreboard bench for pvr_vram_arb: one instance at READ_LAT=1, one at 3,
// sharing stimulus; expected events are queued by the directed tests.
module tb_pvr_vram_arb;

  typedef struct {
    int          cyc;
    logic [2:0]  bits;
    logic [31:0] d0;
    logic [31:0] d1;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_rd;
  logic [2:0]  req_wr;
  logic [71:0] req_addr;
  logic [95:0] req_wdata;
  logic [31:0] vram_din;
  logic        vram_wait;

  logic [2:0]  req_ack, req_rvalid;
  logic [31:0] req_rdata;
  logic        vram_rd, vram_wr;
  logic [23:0] vram_addr;
  logic [31:0] vram_dout;

  logic [2:0]  ack3, rv3;
  logic [31:0] rd3;
  logic        vrd3, vwr3;
  logic [23:0] vaddr3;
  logic [31:0] vdout3;

  int cyc = 0;
  int dbc = -1;
  int checks = 0;
  int failures = 0;

  ev_t q_cmd[$];
  ev_t q_ack[$];
  ev_t q_rv1[$];
  ev_t q_rv3[$];

  pvr_vram_arb #(.READ_LAT(1)) u_dut (
    .clock(clk), .reset_n(rst_n),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_addr(vram_addr), .vram_dout(vram_dout),
    .vram_din(vram_din), .vram_wait(vram_wait)
  );

  pvr_vram_arb #(.READ_LAT(3)) u_lat3 (
    .clock(clk), .reset_n(rst_n),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(ack3), .req_rvalid(rv3), .req_rdata(rd3),
    .vram_rd(vrd3), .vram_wr(vwr3),
    .vram_addr(vaddr3), .vram_dout(vdout3),
    .vram_din(vram_din), .vram_wait(vram_wait)
  );

  function automatic logic [31:0] pat(input int c);
    return 32'hC0DE0000 + 32'(c);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign vram_din = (cyc == dbc) ? 32'hDEADBEEF : pat(cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input int c, input logic [2:0] b,
                      input logic [31:0] d0, input logic [31:0] d1);
    ev_t e;
    e = '{cyc: c, bits: b, d0: d0, d1: d1};
    case (w)
      0: q_cmd.push_back(e);
      1: q_ack.push_back(e);
      2: q_rv1.push_back(e);
      default: q_rv3.push_back(e);
    endcase
  endtask

  task automatic chk(input string nm, input bit ok,
                     input string got, input string exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", nm, got, exp);
    end
  endtask

  task automatic mon(input int w, input string nm, input logic [2:0] b,
                     input logic [31:0] d0, input logic [31:0] d1);
    ev_t e;
    bit  ok;
    e = '{cyc: -1, bits: 3'b000, d0: 32'h0, d1: 32'h0};
    case (w)
      0: if (q_cmd.size() > 0) e = q_cmd.pop_front();
      1: if (q_ack.size() > 0) e = q_ack.pop_front();
      2: if (q_rv1.size() > 0) e = q_rv1.pop_front();
      default: if (q_rv3.size() > 0) e = q_rv3.pop_front();
    endcase
    ok = (e.cyc == cyc) && (e.bits == b);
    if (w != 1) ok = ok && (e.d0 == d0);
    if (w == 0 && e.bits[1]) ok = ok && (e.d1 == d1);
    chk(nm, ok,
        $sformatf("cyc=%0d bits=%b d0=%h d1=%h", cyc, b, d0, d1),
        $sformatf("cyc=%0d bits=%b d0=%h d1=%h", e.cyc, e.bits, e.d0, e.d1));
  endtask

  always @(negedge clk) begin
    if (vram_rd || vram_wr)
      mon(0, "cmd", {1'b0, vram_wr, vram_rd}, {8'h0, vram_addr}, vram_dout);
    if (|req_ack)
      mon(1, "ack", req_ack, 32'h0, 32'h0);
    if (|req_rvalid)
      mon(2, "rvalid_lat1", req_rvalid, req_rdata, 32'h0);
    if (|rv3)
      mon(3, "rvalid_lat3", rv3, rd3, 32'h0);
  end

  task automatic chk_zero(input string nm);
    logic [95:0] o1, o3;
    o1 = {vram_rd, vram_wr, vram_addr, vram_dout, req_ack, req_rvalid, req_rdata};
    o3 = {vrd3, vwr3, vaddr3, vdout3, ack3, rv3, rd3};
    chk({nm, "_lat1"}, o1 == 96'h0, $sformatf("%h", o1), "all zero");
    chk({nm, "_lat3"}, o3 == 96'h0, $sformatf("%h", o3), "all zero");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int c0;
    int a;
    int g;
    int order [6];
`ifdef VRAM_ARB_RR_EN
    order = '{0, 1, 2, 0, 1, 2};
`else
    order = '{0, 1, 0, 1, 0, 1};
`endif
    rst_n     = 1'b0;
    req_rd    = 3'b000;
    req_wr    = 3'b000;
    req_addr  = 72'h0;
    req_wdata = 96'h0;
    vram_wait = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset_state");
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // all three read continuously
    c0 = cyc;
    req_addr = {24'h0A0002, 24'h0A0001, 24'h0A0000};
    req_rd   = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = order[k];
      a = c0 + 1 + 2 * k;
      push(0, a, 3'b001, 32'h0A0000 + 32'(g), 32'h0);
      push(1, a + 1, 3'(1 << g), 32'h0, 32'h0);
      push(2, a + 2, 3'(1 << g), pat(a + 1), 32'h0);
      push(3, a + 4, 3'(1 << g), pat(a + 3), 32'h0);
    end
    repeat (12) tick();
    req_rd = 3'b000;
    repeat (8) tick();

    // single read from requester 0
    c0 = cyc;
    req_addr[23:0] = 24'h000100;
    req_rd[0] = 1'b1;
    dbc = c0 + 2;
    push(0, c0 + 1, 3'b001, 32'h000100, 32'h0);
    push(1, c0 + 2, 3'b001, 32'h0, 32'h0);
    push(2, c0 + 3, 3'b001, 32'hDEADBEEF, 32'h0);
    push(3, c0 + 5, 3'b001, pat(c0 + 4), 32'h0);
    repeat (3) tick();
    req_rd = 3'b000;
    tick();
    @(negedge clk);
    chk("rdata_hold", req_rdata == 32'hDEADBEEF && req_rvalid == 3'b000,
        $sformatf("rdata=%h rvalid=%b", req_rdata, req_rvalid),
        "rdata=deadbeef rvalid=000");
    repeat (4) tick();

    // write from requester 1 stalled three cycles
    c0 = cyc;
    req_addr[47:24]  = 24'h7FFFFC;
    req_wdata[63:32] = 32'h12345678;
    req_wr[1] = 1'b1;
    vram_wait = 1'b1;
    for (int k = 1; k <= 4; k++)
      push(0, c0 + k, 3'b010, 32'h7FFFFC, 32'h12345678);
    push(1, c0 + 5, 3'b010, 32'h0, 32'h0);
    repeat (4) tick();
    vram_wait = 1'b0;
    tick();
    tick();
    req_wr = 3'b000;
    repeat (4) tick();

    // read and write both high: write wins
    c0 = cyc;
    req_addr[23:0]  = 24'h000200;
    req_wdata[31:0] = 32'hAABBCCDD;
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    push(0, c0 + 1, 3'b010, 32'h000200, 32'hAABBCCDD);
    push(1, c0 + 2, 3'b001, 32'h0, 32'h0);
    repeat (3) tick();
    req_rd = 3'b000;
    req_wr = 3'b000;
    repeat (4) tick();

    // back-to-back reads from 2 then 0
    c0 = cyc;
    req_addr[71:48] = 24'h000300;
    req_rd[2] = 1'b1;
    push(0, c0 + 1, 3'b001, 32'h000300, 32'h0);
    push(1, c0 + 2, 3'b100, 32'h0, 32'h0);
    push(2, c0 + 3, 3'b100, pat(c0 + 2), 32'h0);
    push(3, c0 + 5, 3'b100, pat(c0 + 4), 32'h0);
    tick();
    req_addr[23:0] = 24'h000400;
    req_rd[0] = 1'b1;
    push(0, c0 + 3, 3'b001, 32'h000400, 32'h0);
    push(1, c0 + 4, 3'b001, 32'h0, 32'h0);
    push(2, c0 + 5, 3'b001, pat(c0 + 4), 32'h0);
    push(3, c0 + 7, 3'b001, pat(c0 + 6), 32'h0);
    tick();
    tick();
    req_rd[2] = 1'b0;
    tick();
    tick();
    req_rd[0] = 1'b0;
    repeat (5) tick();

    // reset during a command with a read outstanding
    c0 = cyc;
    req_addr[47:24] = 24'h000500;
    req_rd[1] = 1'b1;
    push(0, c0 + 1, 3'b001, 32'h000500, 32'h0);
    push(1, c0 + 2, 3'b010, 32'h0, 32'h0);
    tick();
    req_addr[23:0] = 24'h000600;
    req_rd[0] = 1'b1;
    tick();
    tick();
    rst_n  = 1'b0;
    req_rd = 3'b000;
    @(negedge clk);
    chk_zero("reset_mid_cmd");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    chk("queues_drained",
        (q_cmd.size() + q_ack.size() + q_rv1.size() + q_rv3.size()) == 0,
        $sformatf("cmd=%0d ack=%0d rv1=%0d rv3=%0d left",
                  q_cmd.size(), q_ack.size(), q_rv1.size(), q_rv3.size()),
        "none left");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
